// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared types, error data and address decode for the peripheral bus.
package periph_bus_pkg;
   typedef enum logic [0:0] {IDLE = 1'b0, WAIT_READ = 1'b1} bus_state_t;
   localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
   function automatic logic slot_hit(input logic [31:0] addr, input logic [31:0] base, input int region_bits);
      return (addr >> region_bits) == (base >> region_bits);
   endfunction
endpackage

// File: rtl/periph_bus_decoder_timeout.sv
// bus_timeout_counter: counts wait cycles of a pending read, flags the last allowed one.
module bus_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign cnt_d = clear_i ? '0 : enable_i ? cnt_q + 1'b1 : cnt_q;
   // expiry is flagged one cycle early so the registered error lands on the TIMEOUT-th cycle
   assign expired_o = enable_i & (cnt_q == W'(TIMEOUT - 1));
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/periph_bus_decoder.sv
// periph_bus_decoder: decodes CPU data-port accesses into peripheral strobes
// and returns read data, tracking one outstanding read with a timeout.
module periph_bus_decoder
   import periph_bus_pkg::*;
#(
   parameter int          SLOTS       = 4,
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
   parameter int          REGION_BITS = 16,
   parameter int          SLOT_SHIFT  = 8,
   parameter int          TIMEOUT     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_read_i,
   input  logic                  cpu_write_i,
   input  logic [31:0]           cpu_address_i,
   input  logic [31:0]           cpu_data_i,
   output logic                  cpu_wait_o,
   output logic                  cpu_read_valid_o,
   output logic [31:0]           cpu_data_o,
   output logic                  cpu_bus_error_o,
   output logic [SLOTS-1:0]      per_read_o,
   output logic [SLOTS-1:0]      per_write_o,
   output logic [31:0]           per_data_o,
   input  logic [SLOTS-1:0]      per_read_valid_i,
   input  logic [SLOTS*32-1:0]   per_data_i
);
   localparam int SW = $clog2(SLOTS);
   bus_state_t state_q, state_d;
   logic [SW-1:0] slot_q, slot_d, slot;
   logic [SLOTS-1:0] per_read_q, per_read_d, per_write_q, per_write_d, slot_oh;
   logic [31:0] per_data_q, per_data_d, cpu_data_q, cpu_data_d;
   logic rvalid_q, rvalid_d, err_q, err_d;
   logic idle, hit, rd, wr, illegal, ret, expired;
   assign idle = state_q == IDLE;
   assign hit = slot_hit(cpu_address_i, BASE_ADDR, REGION_BITS);
   assign slot = cpu_address_i[SLOT_SHIFT +: SW];
   assign slot_oh = SLOTS'(1) << slot;
   assign illegal = idle & cpu_read_i & cpu_write_i;
   assign rd = idle & cpu_read_i & ~cpu_write_i;
   assign wr = idle & cpu_write_i & ~cpu_read_i;
   // only the pending slot can complete the read; valids from other slots are ignored
   assign ret = ~idle & per_read_valid_i[slot_q];
   bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (rd & hit),
      .enable_i  (~idle),
      .expired_o (expired)
   );
   always_comb begin
      state_d    = (rd & hit) ? WAIT_READ : (ret | expired) ? IDLE : state_q;
      slot_d     = (rd & hit) ? slot : slot_q;
      per_read_d = (rd & hit) ? slot_oh : '0;
      per_write_d = (wr & hit) ? slot_oh : '0;
      per_data_d = (wr & hit) ? cpu_data_i : per_data_q;
      rvalid_d   = (rd & ~hit) | ret | expired;
      err_d      = illegal | ((rd | wr) & ~hit) | (~ret & expired);
      cpu_data_d = ret ? per_data_i[32*slot_q +: 32] : ((rd & ~hit) | expired) ? BUS_ERR_DATA : cpu_data_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         per_read_q  <= '0;
         per_write_q <= '0;
         per_data_q  <= '0;
         cpu_data_q  <= '0;
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         per_read_q  <= per_read_d;
         per_write_q <= per_write_d;
         per_data_q  <= per_data_d;
         cpu_data_q  <= cpu_data_d;
         rvalid_q    <= rvalid_d;
         err_q       <= err_d;
      end
   end
   assign cpu_wait_o       = ~idle;
   assign cpu_read_valid_o = rvalid_q;
   assign cpu_data_o       = cpu_data_q;
   assign cpu_bus_error_o  = err_q;
   assign per_read_o       = per_read_q;
   assign per_write_o      = per_write_q;
   assign per_data_o       = per_data_q;
endmodule

// File: tb/tb_periph_bus_decoder.sv
// tb_periph_bus_decoder: directed checks of decode, read return, timeout, errors and reset.
module tb_periph_bus_decoder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cpu_read = 1'b0, cpu_write = 1'b0;
   logic [31:0] cpu_address = '0, cpu_data_in = '0;
   logic cpu_wait, cpu_read_valid, cpu_bus_error;
   logic [31:0] cpu_data_out, per_data_out;
   logic [3:0] per_read, per_write, per_read_valid;
   logic [127:0] per_data_in;
   logic inj2 = 1'b0, inj3 = 1'b0;
   logic [1:0] d1 = '0, d2 = '0;
   logic [31:0] io_reg = '0;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   // io-style slots 0 and 1 answer two cycles after the strobe; slot 0 also latches writes
   always @(posedge clk) begin
      d1 <= per_read[1:0];
      d2 <= d1;
      if (per_write[0]) io_reg <= per_data_out;
   end
   assign per_read_valid = {inj3, inj2, d2};
   assign per_data_in = {32'h3333_3333, 32'h2222_2222, io_reg, io_reg};

   periph_bus_decoder dut (
      .clk              (clk),
      .reset            (reset),
      .cpu_read_i       (cpu_read),
      .cpu_write_i      (cpu_write),
      .cpu_address_i    (cpu_address),
      .cpu_data_i       (cpu_data_in),
      .cpu_wait_o       (cpu_wait),
      .cpu_read_valid_o (cpu_read_valid),
      .cpu_data_o       (cpu_data_out),
      .cpu_bus_error_o  (cpu_bus_error),
      .per_read_o       (per_read),
      .per_write_o      (per_write),
      .per_data_o       (per_data_out),
      .per_read_valid_i (per_read_valid),
      .per_data_i       (per_data_in)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // issues a read in the current idle cycle and returns latency to cpu_read_valid (bounded)
   task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d, output logic e);
      cpu_read = 1'b1;
      cpu_address = a;
      step;
      cpu_read = 1'b0;
      lat = 1;
      while (!cpu_read_valid && lat < 40) begin
         step;
         lat++;
      end
      d = cpu_data_out;
      e = cpu_bus_error;
   endtask

   task automatic test_reset;
      logic [104:0] obs;
      reset = 1'b1;
      step;
      step;
      obs = {cpu_wait, cpu_read_valid, cpu_bus_error, cpu_data_out, per_read, per_write, per_data_out};
      tests++; if (obs !== '0) begin fails++; $display("FAIL reset_outputs got %h exp 0", obs); end
      reset = 1'b0;
      step;
   endtask

   task automatic test_write;
      tests++; if (cpu_wait !== 1'b0) begin fails++; $display("FAIL write_accept wait got %b exp 0", cpu_wait); end
      cpu_write = 1'b1; cpu_address = 32'hFFFF_0000; cpu_data_in = 32'h0000_00A5;
      step;
      cpu_write = 1'b0;
      tests++; if (per_write !== 4'b0001) begin fails++; $display("FAIL write_strobe got %b exp 0001", per_write); end
      tests++; if (per_data_out !== 32'hA5) begin fails++; $display("FAIL write_data got %h exp 000000a5", per_data_out); end
      tests++; if ({per_read, cpu_bus_error, cpu_read_valid} !== '0) begin fails++; $display("FAIL write_side got %b exp 0", {per_read, cpu_bus_error, cpu_read_valid}); end
      step;
      tests++; if (io_reg !== 32'hA5) begin fails++; $display("FAIL io_out got %h exp 000000a5", io_reg); end
      tests++; if (per_write !== 4'b0000) begin fails++; $display("FAIL write_pulse got %b exp 0000", per_write); end
   endtask

   task automatic test_read_io;
      cpu_read = 1'b1; cpu_address = 32'hFFFF_0100;
      step;
      cpu_read = 1'b0;
      tests++; if (per_read !== 4'b0010) begin fails++; $display("FAIL read_strobe got %b exp 0010", per_read); end
      tests++; if (cpu_wait !== 1'b1) begin fails++; $display("FAIL read_wait1 got %b exp 1", cpu_wait); end
      step;
      step;
      tests++; if ({cpu_wait, cpu_read_valid} !== 2'b10) begin fails++; $display("FAIL read_wait3 got %b exp 10", {cpu_wait, cpu_read_valid}); end
      step;
      tests++; if ({cpu_wait, cpu_read_valid, cpu_bus_error} !== 3'b010) begin fails++; $display("FAIL read_done got %b exp 010", {cpu_wait, cpu_read_valid, cpu_bus_error}); end
      tests++; if (cpu_data_out !== 32'hA5) begin fails++; $display("FAIL read_data got %h exp 000000a5", cpu_data_out); end
      step;
      tests++; if (cpu_read_valid !== 1'b0) begin fails++; $display("FAIL read_pulse got %b exp 0", cpu_read_valid); end
   endtask

   task automatic test_miss;
      cpu_read = 1'b1; cpu_address = 32'h1234_0000;
      step;
      cpu_read = 1'b0;
      tests++; if ({cpu_read_valid, cpu_bus_error, cpu_wait, per_read} !== 7'b1100000) begin fails++; $display("FAIL miss_read got %b exp 1100000", {cpu_read_valid, cpu_bus_error, cpu_wait, per_read}); end
      tests++; if (cpu_data_out !== 32'hDEAD_BEEF) begin fails++; $display("FAIL miss_data got %h exp deadbeef", cpu_data_out); end
      cpu_write = 1'b1; cpu_address = 32'h0000_0100; cpu_data_in = 32'h77;
      step;
      cpu_write = 1'b0;
      tests++; if ({cpu_bus_error, cpu_read_valid, per_write} !== 6'b100000) begin fails++; $display("FAIL miss_write got %b exp 100000", {cpu_bus_error, cpu_read_valid, per_write}); end
      step;
   endtask

   task automatic test_timeout;
      int lat; logic [31:0] d; logic e;
      do_read(32'hFFFF_0200, lat, d, e);
      tests++; if (lat !== 17) begin fails++; $display("FAIL timeout_latency got %0d exp 17", lat); end
      tests++; if ({e, d} !== {1'b1, 32'hDEAD_BEEF}) begin fails++; $display("FAIL timeout_resp got %b/%h exp 1/deadbeef", e, d); end
      tests++; if (cpu_wait !== 1'b0) begin fails++; $display("FAIL timeout_idle got %b exp 0", cpu_wait); end
      do_read(32'hFFFF_0000, lat, d, e);
      tests++; if ({lat, e, d} !== {32'd4, 1'b0, 32'hA5}) begin fails++; $display("FAIL after_timeout got %0d/%b/%h exp 4/0/000000a5", lat, e, d); end
   endtask

   task automatic test_valid_wins;
      cpu_read = 1'b1; cpu_address = 32'hFFFF_0200;
      step;
      cpu_read = 1'b0;
      repeat (15) step;
      tests++; if ({cpu_wait, cpu_read_valid} !== 2'b10) begin fails++; $display("FAIL edge_pending got %b exp 10", {cpu_wait, cpu_read_valid}); end
      inj2 = 1'b1;
      step;
      inj2 = 1'b0;
      tests++; if ({cpu_read_valid, cpu_bus_error, cpu_data_out} !== {2'b10, 32'h2222_2222}) begin fails++; $display("FAIL valid_wins got %b/%b/%h exp 1/0/22222222", cpu_read_valid, cpu_bus_error, cpu_data_out); end
      step;
   endtask

   task automatic test_other_slot;
      cpu_read = 1'b1; cpu_address = 32'hFFFF_0100;
      step;
      cpu_read = 1'b0;
      step;
      inj3 = 1'b1;
      step;
      inj3 = 1'b0;
      tests++; if ({cpu_wait, cpu_read_valid} !== 2'b10) begin fails++; $display("FAIL other_slot_ignored got %b exp 10", {cpu_wait, cpu_read_valid}); end
      step;
      tests++; if ({cpu_read_valid, cpu_bus_error, cpu_data_out} !== {2'b10, 32'hA5}) begin fails++; $display("FAIL other_slot_data got %b/%b/%h exp 1/0/000000a5", cpu_read_valid, cpu_bus_error, cpu_data_out); end
      step;
   endtask

   task automatic test_illegal;
      cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 32'hFFFF_0000; cpu_data_in = 32'h55;
      step;
      cpu_read = 1'b0; cpu_write = 1'b0;
      tests++; if ({cpu_bus_error, cpu_read_valid, cpu_wait, per_read, per_write} !== 11'b100_0000_0000) begin fails++; $display("FAIL illegal got %b exp 10000000000", {cpu_bus_error, cpu_read_valid, cpu_wait, per_read, per_write}); end
      step;
   endtask

   task automatic test_back_to_back;
      cpu_write = 1'b1; cpu_address = 32'hFFFF_0000; cpu_data_in = 32'h11;
      step;
      cpu_address = 32'hFFFF_0300; cpu_data_in = 32'h22;
      tests++; if ({per_write, per_data_out} !== {4'b0001, 32'h11}) begin fails++; $display("FAIL b2b_first got %b/%h exp 0001/00000011", per_write, per_data_out); end
      step;
      cpu_write = 1'b0;
      tests++; if ({per_write, per_data_out} !== {4'b1000, 32'h22}) begin fails++; $display("FAIL b2b_second got %b/%h exp 1000/00000022", per_write, per_data_out); end
      step;
      tests++; if ({per_write, per_data_out} !== {4'b0000, 32'h22}) begin fails++; $display("FAIL b2b_hold got %b/%h exp 0000/00000022", per_write, per_data_out); end
      cpu_write = 1'b1; cpu_address = 32'hFFFF_0000; cpu_data_in = 32'hA5;
      step;
      cpu_write = 1'b0;
      step;
   endtask

   task automatic test_reset_mid_read;
      int lat; logic [31:0] d; logic e; logic seen;
      cpu_read = 1'b1; cpu_address = 32'hFFFF_0100;
      step;
      cpu_read = 1'b0;
      step;
      reset = 1'b1;
      #1;
      tests++; if ({cpu_wait, cpu_read_valid, cpu_bus_error, cpu_data_out, per_read, per_write, per_data_out} !== '0) begin fails++; $display("FAIL mid_reset_outputs got %b/%b/%b/%h exp all 0", cpu_wait, cpu_read_valid, cpu_bus_error, cpu_data_out); end
      step;
      reset = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         step;
         seen = seen | cpu_read_valid;
      end
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL dropped_read got %b exp 0", seen); end
      do_read(32'hFFFF_0000, lat, d, e);
      tests++; if ({lat, e, d} !== {32'd4, 1'b0, 32'hA5}) begin fails++; $display("FAIL read_after_reset got %0d/%b/%h exp 4/0/000000a5", lat, e, d); end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read_io;
      test_miss;
      test_timeout;
      test_valid_wins;
      test_other_slot;
      test_illegal;
      test_back_to_back;
      test_reset_mid_read;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
